// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: seven-segment scan bus in, digit-change events and digit file out
interface seg7_scan_reader_if;
    logic [2:0]  seg7_sel;
    logic [6:0]  seg7_in;
    logic        dpt_in;
    logic        ev_ready;
    logic        ev_valid;
    logic [3:0]  ev_bcd;
    logic [2:0]  ev_pos;
    logic        ev_dpt;
    logic [31:0] digits_out;
    logic [7:0]  known_out;
    logic        err_out;
    logic        overrun_out;
    modport master (
        output seg7_sel, seg7_in, dpt_in, ev_ready,
        input  ev_valid, ev_bcd, ev_pos, ev_dpt, digits_out, known_out, err_out, overrun_out
    );
    modport slave (
        input  seg7_sel, seg7_in, dpt_in, ev_ready,
        output ev_valid, ev_bcd, ev_pos, ev_dpt, digits_out, known_out, err_out, overrun_out
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: debounces a multiplexed seven-segment bus, decodes it back to BCD and reports digit changes
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input logic               clk_in,
    input logic               reset_n,
    seg7_scan_reader_if.slave bus
);
    typedef enum logic {TRACK, LOCKED} state_t;
    state_t      state_q, state_d;
    logic [10:0] s_q, s_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q, dp_d, known_q, known_d;
    logic        ev_valid_q, ev_valid_d, ev_dpt_q, ev_dpt_d;
    logic [3:0]  ev_bcd_q, ev_bcd_d;
    logic [2:0]  ev_pos_q, ev_pos_d;
    logic        err_q, err_d, ovr_q, ovr_d;
    logic [10:0] t;
    logic        same, accept, dec_ok, ev_new;
    logic [3:0]  dec_bcd;
    logic [2:0]  pos;
    logic [6:0]  pat;
    logic        dpt;
    assign t    = {bus.seg7_sel, bus.seg7_in, bus.dpt_in};
    assign same = t == s_q;
    assign pos  = s_q[10:8];
    assign pat  = s_q[7:1];
    assign dpt  = s_q[0];
    // Decode the sampled abcdefg pattern back to a BCD digit
    always_comb begin
        dec_ok  = 1'b1;
        dec_bcd = 4'd0;
        case (pat)
            7'b1111110: dec_bcd = 4'd0;
            7'b0110000: dec_bcd = 4'd1;
            7'b1101101: dec_bcd = 4'd2;
            7'b1111001: dec_bcd = 4'd3;
            7'b0110011: dec_bcd = 4'd4;
            7'b1011011: dec_bcd = 4'd5;
            7'b1011111: dec_bcd = 4'd6;
            7'b1110000: dec_bcd = 4'd7;
            7'b1111111: dec_bcd = 4'd8;
            7'b1111011: dec_bcd = 4'd9;
            default:    dec_ok  = 1'b0;
        endcase
    end
    // Debounce FSM: accept once when the count reaches the threshold, then lock until the tuple changes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        s_d     = t;
        cnt_d   = same ? (cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1) : 4'd0;
        if (state_q == TRACK) begin
            if (same && cnt_q == 4'(STABLE_CYCLES)) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end
        end else if (!same) begin
            state_d = TRACK;
        end
    end
    // Accept action on the digit file plus the one-entry event holding register
    always_comb begin
        digits_d   = digits_q;
        dp_d       = dp_q;
        known_d    = known_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        ev_new     = 1'b0;
        ev_valid_d = ev_valid_q && !bus.ev_ready;
        ev_bcd_d   = ev_bcd_q;
        ev_pos_d   = ev_pos_q;
        ev_dpt_d   = ev_dpt_q;
        if (accept && dec_ok) begin
            ev_new = !known_q[pos] || digits_q[pos*4 +: 4] != dec_bcd || dp_q[pos] != dpt;
            digits_d[pos*4 +: 4] = dec_bcd;
            dp_d[pos]            = dpt;
            known_d[pos]         = 1'b1;
        end else if (accept) begin
            known_d[pos] = 1'b0;
            err_d        = err_q || pat != 7'd0;
        end
        if (ev_new && (!ev_valid_q || bus.ev_ready)) begin
            ev_valid_d = 1'b1;
            ev_bcd_d   = dec_bcd;
            ev_pos_d   = pos;
            ev_dpt_d   = dpt;
        end else if (ev_new) begin
            ev_valid_d = 1'b1;
            ovr_d      = 1'b1;
        end
    end
    // State registers with asynchronous active-low clear
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TRACK;
            s_q        <= '0;
            cnt_q      <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            known_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_bcd_q   <= '0;
            ev_pos_q   <= '0;
            ev_dpt_q   <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            known_q    <= known_d;
            ev_valid_q <= ev_valid_d;
            ev_bcd_q   <= ev_bcd_d;
            ev_pos_q   <= ev_pos_d;
            ev_dpt_q   <= ev_dpt_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end
    assign bus.ev_valid    = ev_valid_q;
    assign bus.ev_bcd      = ev_bcd_q;
    assign bus.ev_pos      = ev_pos_q;
    assign bus.ev_dpt      = ev_dpt_q;
    assign bus.digits_out  = digits_q;
    assign bus.known_out   = known_q;
    assign bus.err_out     = err_q;
    assign bus.overrun_out = ovr_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed self-checking bench for seg7_scan_reader
module tb_seg7_scan_reader;
    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   xfers = 0;
    int   x0;
    seg7_scan_reader_if bus ();
    seg7_scan_reader #(.STABLE_CYCLES(4)) dut (.clk_in(clk_in), .reset_n(reset_n), .bus(bus));
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) if (reset_n && bus.ev_valid && bus.ev_ready) xfers <= xfers + 1;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask
    task automatic hold(input logic [2:0] sel, input logic [6:0] seg, input logic dp, input int n);
        bus.seg7_sel = sel;
        bus.seg7_in  = seg;
        bus.dpt_in   = dp;
        tick(n);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.seg7_sel = 3'd0;
        bus.seg7_in  = 7'd0;
        bus.dpt_in   = 1'b0;
        bus.ev_ready = 1'b1;
        tick(2);
        chk("rst_valid", bus.ev_valid, 0);
        chk("rst_digits", bus.digits_out, 0);
        chk("rst_known", bus.known_out, 0);
        chk("rst_err", bus.err_out, 0);
        chk("rst_ovr", bus.overrun_out, 0);
        reset_n = 1'b1;
        tick(10);
        chk("blank0_known", bus.known_out, 0);
        chk("blank0_valid", bus.ev_valid, 0);
        chk("blank0_err", bus.err_out, 0);
        // stability: sel 3, digit 5, dp 1
        x0 = xfers;
        hold(3'd3, 7'b1011011, 1'b1, 5);
        chk("stab_early_valid", bus.ev_valid, 0);
        chk("stab_early_known", bus.known_out, 0);
        tick(1);
        chk("stab_valid", bus.ev_valid, 1);
        chk("stab_bcd", bus.ev_bcd, 5);
        chk("stab_pos", bus.ev_pos, 3);
        chk("stab_dpt", bus.ev_dpt, 1);
        chk("stab_digit", bus.digits_out[15:12], 5);
        chk("stab_known", bus.known_out, 8'h08);
        tick(8);
        chk("stab_one_event", xfers - x0, 1);
        chk("stab_valid_drop", bus.ev_valid, 0);
        // glitch: toggle 1 / 2 every 3 cycles on sel 0
        x0 = xfers;
        for (int i = 0; i < 10; i++) hold(3'd0, (i % 2 == 0) ? 7'b0110000 : 7'b1101101, 1'b0, 3);
        chk("glitch_events", xfers - x0, 0);
        chk("glitch_known0", bus.known_out[0], 0);
        hold(3'd0, 7'b1101101, 1'b0, 8);
        chk("glitch_hold_events", xfers - x0, 1);
        chk("glitch_hold_bcd", bus.ev_bcd, 2);
        chk("glitch_hold_digit", bus.digits_out[3:0], 2);
        // repeat suppression on sel 1
        hold(3'd1, 7'b1110000, 1'b0, 8);
        chk("rep_bcd7", bus.ev_bcd, 7);
        x0 = xfers;
        hold(3'd2, 7'b0000000, 1'b0, 8);
        hold(3'd1, 7'b1110000, 1'b0, 8);
        chk("rep_suppressed", xfers - x0, 0);
        hold(3'd1, 7'b1111111, 1'b0, 8);
        chk("rep_change_events", xfers - x0, 1);
        chk("rep_change_bcd", bus.ev_bcd, 8);
        chk("rep_change_pos", bus.ev_pos, 1);
        // invalid then blank
        x0 = xfers;
        hold(3'd4, 7'b1000001, 1'b0, 8);
        chk("inv_err", bus.err_out, 1);
        chk("inv_known4", bus.known_out[4], 0);
        chk("inv_events", xfers - x0, 0);
        hold(3'd5, 7'b0000000, 1'b0, 8);
        chk("blank_err_sticky", bus.err_out, 1);
        chk("blank_events", xfers - x0, 0);
        chk("blank_known", bus.known_out, 8'h0B);
        // backpressure
        bus.ev_ready = 1'b0;
        hold(3'd0, 7'b0110000, 1'b0, 8);
        chk("bp_first_valid", bus.ev_valid, 1);
        chk("bp_no_ovr_yet", bus.overrun_out, 0);
        hold(3'd1, 7'b1101101, 1'b0, 8);
        hold(3'd2, 7'b1111001, 1'b0, 8);
        chk("bp_valid", bus.ev_valid, 1);
        chk("bp_pos", bus.ev_pos, 0);
        chk("bp_bcd", bus.ev_bcd, 1);
        chk("bp_ovr", bus.overrun_out, 1);
        chk("bp_digits", bus.digits_out[11:0], 12'h321);
        chk("bp_known", bus.known_out, 8'h0F);
        bus.ev_ready = 1'b1;
        tick(1);
        chk("bp_drain", bus.ev_valid, 0);
        // reset mid-debounce
        hold(3'd6, 7'b0110011, 1'b1, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_digits", bus.digits_out, 0);
        chk("mid_rst_known", bus.known_out, 0);
        chk("mid_rst_err", bus.err_out, 0);
        chk("mid_rst_ovr", bus.overrun_out, 0);
        chk("mid_rst_pos", bus.ev_pos, 0);
        chk("mid_rst_bcd", bus.ev_bcd, 0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("post_rst_early", bus.ev_valid, 0);
        chk("post_rst_early_known", bus.known_out, 0);
        tick(1);
        chk("post_rst_valid", bus.ev_valid, 1);
        chk("post_rst_bcd", bus.ev_bcd, 4);
        chk("post_rst_pos", bus.ev_pos, 6);
        chk("post_rst_dpt", bus.ev_dpt, 1);
        chk("post_rst_known", bus.known_out, 8'h40);
        chk("post_rst_digits", bus.digits_out, 32'h0400_0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
